// File: rtl/lab_led_chaser.sv
// lab_led_chaser: decodes the 4-bit LED-control PIO value into a chase/bounce running light.
module lab_led_chaser #(
    parameter int LED_W    = 10,
    parameter int TICK_DIV = 5000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               ctrl,
    output logic [LED_W-1:0]         led,
    output logic                     step,
    output logic [$clog2(LED_W)-1:0] pos
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = $clog2(LED_W);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] POS_MAX = AW'(LED_W - 1);
    localparam logic [LED_W-1:0] ONE = LED_W'(1);
    logic [3:0]    ctrl_q;
    logic [PW-1:0] pre_cnt;
    logic [2:0]    tick_cnt;
    logic          dir;
    logic          change, base_tick, step_now, nxt_dir;
    logic [AW-1:0] nxt_pos;
    assign change    = ctrl != ctrl_q;
    assign base_tick = pre_cnt == PRE_MAX;
    // A ctrl change wins over a coincident terminal count.
    assign step_now  = ctrl_q[3] && !change && base_tick && tick_cnt == (3'd7 >> ctrl_q[1:0]);
    // Bounce reverses at either end without dwelling; chase wraps and forces dir low.
    assign nxt_dir   = ctrl_q[2] && (dir ? pos != '0 : pos == POS_MAX);
    assign nxt_pos   = !ctrl_q[2] ? (pos == POS_MAX ? '0 : pos + 1'b1)
                                  : (nxt_dir ? pos - 1'b1 : pos + 1'b1);
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= '0;
            pre_cnt  <= '0;
            tick_cnt <= '0;
            pos      <= '0;
            dir      <= 1'b0;
            step     <= 1'b0;
            led      <= '0;
        end else begin
            ctrl_q <= ctrl;
            step   <= step_now;
            if (change || !ctrl_q[3]) begin
                pre_cnt  <= '0;
                tick_cnt <= '0;
                if (!ctrl_q[3] || !ctrl[3]) begin
                    pos <= '0;
                    dir <= 1'b0;
                    led <= ctrl[3] ? ONE : '0;
                end
            end else begin
                pre_cnt <= base_tick ? '0 : pre_cnt + 1'b1;
                if (base_tick)
                    tick_cnt <= step_now ? 3'd0 : tick_cnt + 3'd1;
                if (step_now) begin
                    pos <= nxt_pos;
                    dir <= nxt_dir;
                    led <= ONE << nxt_pos;
                end
            end
        end
    end
endmodule

// File: tb/tb_lab_led_chaser.sv
// tb_lab_led_chaser: directed scenarios for lab_led_chaser with LED_W=4, TICK_DIV=2.
module tb_lab_led_chaser;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] ctrl = 4'h0;
    logic [3:0] led;
    logic       step;
    logic [1:0] pos;
    int n_cmp = 0;
    int n_err = 0;

    lab_led_chaser #(.LED_W(4), .TICK_DIV(2)) dut (
        .clk(clk), .reset(reset), .ctrl(ctrl), .led(led), .step(step), .pos(pos)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] c);
        reset = 1'b1;
        ctrl = c;
        repeat (2) cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        logic [3:0] el [3];
        logic       es [3];
        el = '{4'b0001, 4'b0001, 4'b0010};
        es = '{1'b0, 1'b0, 1'b1};
        reset = 1'b1;
        ctrl = 4'hB;
        for (int k = 0; k < 5; k++) begin
            cyc();
            n_cmp++;
            if (led !== 4'b0 || step !== 1'b0 || pos !== 2'd0) begin
                n_err++;
                $display("FAIL reset k=%0d got led=%b step=%b pos=%0d want 0/0/0", k, led, step, pos);
            end
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_cmp++;
            if (led !== el[k] || step !== es[k]) begin
                n_err++;
                $display("FAIL reset_release k=%0d got led=%b step=%b want led=%b step=%b", k, led, step, el[k], es[k]);
            end
        end
    endtask

    task automatic test_chase;
        logic [3:0] el [10];
        el = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
        do_reset(4'b1011);
        for (int k = 0; k < 10; k++) begin
            logic es;
            cyc();
            es = (k > 0) && (k % 2 == 0);
            n_cmp++;
            if (led !== el[k] || step !== es) begin
                n_err++;
                $display("FAIL chase k=%0d got led=%b step=%b want led=%b step=%b", k, led, step, el[k], es);
            end
        end
    endtask

    task automatic test_bounce;
        logic [3:0] el [16];
        el = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000,
               4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
        do_reset(4'b1111);
        for (int k = 0; k < 16; k++) begin
            logic es;
            cyc();
            es = (k > 0) && (k % 2 == 0);
            n_cmp++;
            if (led !== el[k] || step !== es) begin
                n_err++;
                $display("FAIL bounce k=%0d got led=%b step=%b want led=%b step=%b", k, led, step, el[k], es);
            end
        end
    endtask

    task automatic test_speed_change;
        logic [3:0] el [3];
        logic       es [3];
        el = '{4'b0010, 4'b0010, 4'b0100};
        es = '{1'b0, 1'b0, 1'b1};
        do_reset(4'b1000);
        cyc();
        for (int k = 1; k <= 26; k++) begin
            logic es1;
            cyc();
            es1 = (k == 16);
            n_cmp++;
            if (step !== es1) begin
                n_err++;
                $display("FAIL slow_step k=%0d got step=%b want %b", k, step, es1);
            end
        end
        n_cmp++;
        if (led !== 4'b0010) begin
            n_err++;
            $display("FAIL slow_pos got led=%b want 0010", led);
        end
        ctrl = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_cmp++;
            if (led !== el[k] || step !== es[k]) begin
                n_err++;
                $display("FAIL speed_change k=%0d got led=%b step=%b want led=%b step=%b", k, led, step, el[k], es[k]);
            end
        end
    endtask

    task automatic test_disable;
        logic [3:0] el [5];
        logic       es [5];
        el = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100};
        es = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset(4'b1111);
        repeat (9) cyc();
        n_cmp++;
        if (led !== 4'b0100) begin
            n_err++;
            $display("FAIL disable_setup got led=%b want 0100", led);
        end
        ctrl = 4'b0111;
        for (int k = 0; k < 6; k++) begin
            cyc();
            n_cmp++;
            if (led !== 4'b0 || step !== 1'b0 || pos !== 2'd0) begin
                n_err++;
                $display("FAIL disabled k=%0d got led=%b step=%b pos=%0d want 0/0/0", k, led, step, pos);
            end
        end
        ctrl = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cyc();
            n_cmp++;
            if (led !== el[k] || step !== es[k]) begin
                n_err++;
                $display("FAIL reenable k=%0d got led=%b step=%b want led=%b step=%b", k, led, step, el[k], es[k]);
            end
        end
    endtask

    task automatic test_coincident;
        logic [3:0] el [3];
        logic       es [3];
        el = '{4'b0001, 4'b0001, 4'b0010};
        es = '{1'b0, 1'b0, 1'b1};
        do_reset(4'b1011);
        repeat (2) cyc();
        ctrl = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_cmp++;
            if (led !== el[k] || step !== es[k]) begin
                n_err++;
                $display("FAIL coincident k=%0d got led=%b step=%b want led=%b step=%b", k, led, step, el[k], es[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_chase();
        test_bounce();
        test_speed_change();
        test_disable();
        test_coincident();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
